// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone burst master.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] WB_OK  = 2'd0;
    localparam logic [1:0] WB_ERR = 2'd1;
    localparam logic [1:0] WB_TMO = 2'd2;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_tmo_cnt.sv
// Stall watchdog: counts consecutive run cycles, flags the TMO-th one.
module wb_tmo_cnt #(
    parameter int TMO = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic clear_i,
    output logic expired_o
);
    localparam int CW = $clog2(TMO + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Combinational so the abort lands on the TMO-th stalled edge itself.
    assign expired_o = run_i && (cnt_q == CW'(TMO - 1));

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 master running one single or incrementing-burst block cycle per command.
module wb_burst_master
    import wb_pkg::*;
#(
    parameter int AW   = 26,
    parameter int DW   = 32,
    parameter int MAXB = 8,
    parameter int TMO  = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [AW-1:0]           req_adr_i,
    input  logic [DW/8-1:0]         req_sel_i,
    input  logic [$clog2(MAXB)-1:0] req_len_i,
    output logic                    wdat_rd_o,
    input  logic [DW-1:0]           wdat_i,
    output logic                    rdat_valid_o,
    output logic [DW-1:0]           rdat_o,
    output logic                    done_o,
    output logic [1:0]              status_o,
    output logic [AW-1:0]           adr_o,
    output logic [DW-1:0]           dat_o,
    output logic [DW/8-1:0]         sel_o,
    output logic                    we_o,
    output logic                    stb_o,
    output logic                    cyc_o,
    output logic [2:0]              cti_o,
    input  logic [DW-1:0]           dat_i,
    input  logic                    ack_i,
    input  logic                    err_i
);
    localparam int LW = $clog2(MAXB);
    localparam int SW = DW / 8;

    state_e          state_q, state_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            we_q, we_d;
    logic            stb_q, stb_d;
    logic [2:0]      cti_q, cti_d;
    logic [LW-1:0]   beats_q, beats_d;
    logic [DW-1:0]   rdat_q, rdat_d;
    logic            rdat_valid_q, rdat_valid_d;
    logic            done_q, done_d;
    logic [1:0]      status_q, status_d;

    logic in_bus_s, accept_s, ack_ok_s, err_s, last_s, run_s, tmo_s, abort_s, finish_s;

    assign in_bus_s = (state_q == ST_BUS);
    assign accept_s = req_valid_i && req_ready_o;
    assign ack_ok_s = in_bus_s && ack_i && !err_i;
    assign err_s    = in_bus_s && err_i;
    assign last_s   = (beats_q == '0);
    assign run_s    = in_bus_s && !ack_i && !err_i;
    assign abort_s  = err_s || tmo_s;
    assign finish_s = (ack_ok_s && last_s) || abort_s;

    wb_tmo_cnt #(.TMO(TMO)) u_tmo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .run_i     (run_s),
        .clear_i   (!run_s),
        .expired_o (tmo_s)
    );

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = accept_s ? ST_BUS : ST_IDLE;
            ST_BUS:  state_d = finish_s ? ST_DONE : ST_BUS;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // datapath and bus output next values
    always_comb begin
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        we_d         = we_q;
        stb_d        = stb_q;
        cti_d        = cti_q;
        beats_d      = beats_q;
        rdat_d       = rdat_q;
        rdat_valid_d = 1'b0;
        done_d       = 1'b0;
        status_d     = status_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    we_d    = req_we_i;
                    sel_d   = req_sel_i;
                    beats_d = req_len_i;
                    adr_d   = req_adr_i;
                    stb_d   = 1'b1;
                    cti_d   = (req_len_i == '0) ? CTI_CLASSIC : CTI_INCR;
                    dat_d   = req_we_i ? wdat_i : dat_q;
                end else begin
                    stb_d = 1'b0;
                end
            end
            ST_BUS: begin
                if (abort_s) begin
                    stb_d    = 1'b0;
                    cti_d    = CTI_CLASSIC;
                    status_d = err_s ? WB_ERR : WB_TMO;
                    done_d   = 1'b1;
                end else if (ack_ok_s) begin
                    rdat_valid_d = !we_q;
                    rdat_d       = we_q ? rdat_q : dat_i;
                    if (last_s) begin
                        stb_d    = 1'b0;
                        cti_d    = CTI_CLASSIC;
                        status_d = WB_OK;
                        done_d   = 1'b1;
                    end else begin
                        adr_d   = adr_q + AW'(SW);
                        beats_d = beats_q - LW'(1);
                        cti_d   = (beats_q == LW'(1)) ? CTI_EOB : CTI_INCR;
                        dat_d   = we_q ? wdat_i : dat_q;
                    end
                end else begin
                    stb_d = 1'b1;
                end
            end
            ST_DONE: stb_d = 1'b0;
            default: stb_d = 1'b0;
        endcase
    end

    // registered outputs and datapath
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            stb_q        <= 1'b0;
            cti_q        <= CTI_CLASSIC;
            beats_q      <= '0;
            rdat_q       <= '0;
            rdat_valid_q <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= WB_OK;
        end else begin
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            stb_q        <= stb_d;
            cti_q        <= cti_d;
            beats_q      <= beats_d;
            rdat_q       <= rdat_d;
            rdat_valid_q <= rdat_valid_d;
            done_q       <= done_d;
            status_q     <= status_d;
        end
    end

    // Write data is popped on accept and on every non-final good ack.
    assign wdat_rd_o    = !rst_i && ((accept_s && req_we_i) || (ack_ok_s && !last_s && we_q));
    assign req_ready_o  = !rst_i && (state_q == ST_IDLE);
    assign adr_o        = adr_q;
    assign dat_o        = dat_q;
    assign sel_o        = sel_q;
    assign we_o         = we_q;
    assign stb_o        = stb_q;
    assign cyc_o        = stb_q;
    assign cti_o        = cti_q;
    assign rdat_o       = rdat_q;
    assign rdat_valid_o = rdat_valid_q;
    assign done_o       = done_q;
    assign status_o     = status_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed, table-driven bench for wb_burst_master with a reactive Wishbone slave.
module tb_wb_burst_master;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [25:0] req_adr_i;
    logic [3:0]  req_sel_i;
    logic [2:0]  req_len_i;
    logic        wdat_rd_o;
    logic [31:0] wdat_i;
    logic        rdat_valid_o;
    logic [31:0] rdat_o;
    logic        done_o;
    logic [1:0]  status_o;
    logic [25:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic        we_o, stb_o, cyc_o;
    logic [2:0]  cti_o;
    logic [31:0] dat_i;
    logic        ack_i, err_i;

    always #5 clk = ~clk;

    wb_burst_master #(.AW(26), .DW(32), .MAXB(8), .TMO(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_adr_i(req_adr_i), .req_sel_i(req_sel_i), .req_len_i(req_len_i),
        .wdat_rd_o(wdat_rd_o), .wdat_i(wdat_i),
        .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o),
        .done_o(done_o), .status_o(status_o),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
        .stb_o(stb_o), .cyc_o(cyc_o), .cti_o(cti_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    typedef struct {
        logic        we;
        logic [25:0] adr;
        logic [2:0]  len;
        int          waits;
        int          err_beat;
        logic        stall;
        logic [31:0] rbase;
        logic [1:0]  exp_status;
        int          exp_stb;
        int          exp_rdv;
        int          exp_pops;
        logic [25:0] exp_last_adr;
        logic [2:0]  exp_last_cti;
        logic [31:0] exp_last_rdat;
    } vec_t;

    int tests = 0;
    int failed = 0;

    int          r_stb, r_rdv, r_pops, r_done, n_acks;
    logic [1:0]  r_status;
    logic [25:0] r_last_adr;
    logic [2:0]  r_last_cti;
    logic [31:0] r_last_rdat;
    logic [25:0] adr_seq [8];
    logic [2:0]  cti_seq [8];
    logic [31:0] dat_seq [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   beat, wctr, guard;
        logic seen_done, prev_ok, a, e;
        logic [31:0] prev_dat;
        r_stb = 0; r_rdv = 0; r_pops = 0; r_done = 0; n_acks = 0;
        r_status = 2'd3; r_last_adr = '0; r_last_cti = 3'b101; r_last_rdat = '0;
        guard = 0;
        do begin
            @(negedge clk); #1; guard++;
        end while (!req_ready_o && guard < 20);
        check("ready_before_cmd", req_ready_o, 1);
        req_valid_i = 1'b1; req_we_i = v.we; req_adr_i = v.adr;
        req_len_i = v.len; req_sel_i = 4'hF; wdat_i = 32'h11;
        #1;
        if (wdat_rd_o) r_pops++;
        beat = 0; wctr = 0; prev_ok = 1'b0; prev_dat = '0; seen_done = 1'b0;
        for (guard = 0; guard < 100 && !seen_done; guard++) begin
            @(negedge clk);
            req_valid_i = 1'b0; a = 1'b0; e = 1'b0;
            if (stb_o) begin
                r_stb++; r_last_adr = adr_o; r_last_cti = cti_o;
                if (!v.stall) begin
                    if (wctr < v.waits) begin
                        wctr++;
                    end else begin
                        a = 1'b1; e = (beat == v.err_beat);
                        dat_i = v.rbase + 32'(beat);
                        if (n_acks < 8) begin
                            adr_seq[n_acks] = adr_o; cti_seq[n_acks] = cti_o; dat_seq[n_acks] = dat_o;
                        end
                        n_acks++; beat++; wctr = 0;
                    end
                end
            end
            ack_i = a; err_i = e;
            wdat_i = 32'h11 * 32'(r_pops + 1);
            #1;
            if (wdat_rd_o) r_pops++;
            if (rdat_valid_o) begin
                r_rdv++;
                check("rdat_data", rdat_o, prev_dat);
                check("rdat_after_ack", prev_ok, 1);
                r_last_rdat = rdat_o;
            end
            prev_ok = a && !e; prev_dat = dat_i;
            if (done_o) begin
                seen_done = 1'b1; r_done++; r_status = status_o;
                check("cyc_low_at_done", cyc_o, 0);
                check("ready_low_at_done", req_ready_o, 0);
            end
        end
        check("done_seen", seen_done, 1);
        @(negedge clk);
        ack_i = 1'b0; err_i = 1'b0;
        #1;
        check("ready_after_done", req_ready_o, 1);
        check("done_single", done_o, 0);
    endtask

    vec_t vecs [6];
    logic [25:0] exp_adr [4];
    logic [2:0]  exp_cti [4];
    logic [31:0] exp_dat [4];
    int acc0, acc1, d0, n_acc, n_dn;
    logic [25:0] badr0, badr1;

    initial begin
        vecs[0] = '{1'b0, 26'h0000100, 3'd0, 2, -1, 1'b0, 32'hDEADBEEF, 2'd0, 3, 1, 0, 26'h0000100, 3'b000, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 26'h3FFFFF8, 3'd3, 0, -1, 1'b0, 32'h0, 2'd0, 4, 0, 4, 26'h0000004, 3'b111, 32'h0};
        vecs[2] = '{1'b0, 26'h0000200, 3'd7, 0, 2, 1'b0, 32'h50000000, 2'd1, 3, 2, 0, 26'h0000208, 3'b010, 32'h50000001};
        vecs[3] = '{1'b0, 26'h0000040, 3'd1, 0, -1, 1'b1, 32'h0, 2'd2, 4, 0, 0, 26'h0000040, 3'b010, 32'h0};
        vecs[4] = '{1'b1, 26'h0001000, 3'd3, 1, 1, 1'b0, 32'h0, 2'd1, 4, 0, 2, 26'h0001004, 3'b010, 32'h0};
        vecs[5] = '{1'b0, 26'h0000010, 3'd1, 1, -1, 1'b0, 32'h60000000, 2'd0, 4, 2, 0, 26'h0000014, 3'b111, 32'h60000001};
        exp_adr = '{26'h3FFFFF8, 26'h3FFFFFC, 26'h0000000, 26'h0000004};
        exp_cti = '{3'b010, 3'b010, 3'b010, 3'b111};
        exp_dat = '{32'h11, 32'h22, 32'h33, 32'h44};

        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_adr_i = '0;
        req_sel_i = '0; req_len_i = '0; wdat_i = '0; dat_i = '0; ack_i = 1'b0; err_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cyc", cyc_o, 0);
        check("rst_stb", stb_o, 0);
        check("rst_we", we_o, 0);
        check("rst_adr", adr_o, 0);
        check("rst_dat", dat_o, 0);
        check("rst_sel", sel_o, 0);
        check("rst_cti", cti_o, 0);
        check("rst_rdv", rdat_valid_o, 0);
        check("rst_done", done_o, 0);
        check("rst_status", status_o, 0);
        check("rst_ready", req_ready_o, 0);
        rst_i = 1'b0;
        @(negedge clk); #1;
        check("ready_after_rst", req_ready_o, 1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            check($sformatf("v%0d_status", i), r_status, vecs[i].exp_status);
            check($sformatf("v%0d_stb_cycles", i), r_stb, vecs[i].exp_stb);
            check($sformatf("v%0d_rdv", i), r_rdv, vecs[i].exp_rdv);
            check($sformatf("v%0d_pops", i), r_pops, vecs[i].exp_pops);
            check($sformatf("v%0d_done", i), r_done, 1);
            check($sformatf("v%0d_last_adr", i), r_last_adr, vecs[i].exp_last_adr);
            check($sformatf("v%0d_last_cti", i), r_last_cti, vecs[i].exp_last_cti);
            if (vecs[i].exp_rdv > 0)
                check($sformatf("v%0d_last_rdat", i), r_last_rdat, vecs[i].exp_last_rdat);
        end

        // Wrapping write burst: per-beat address, cti and data.
        run_vec(vecs[1]);
        check("wr_acks", n_acks, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wr_adr%0d", k), adr_seq[k], exp_adr[k]);
            check($sformatf("wr_cti%0d", k), cti_seq[k], exp_cti[k]);
            check($sformatf("wr_dat%0d", k), dat_seq[k], exp_dat[k]);
        end

        // Reset during beat 2 of a read burst.
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_adr_i = 26'h0000800; req_len_i = 3'd3;
        #1;
        check("mr_accept_ready", req_ready_o, 1);
        @(negedge clk);
        req_valid_i = 1'b0;
        check("mr_beat1_stb", stb_o, 1);
        ack_i = 1'b1; dat_i = 32'hAAAA0000;
        #1;
        @(negedge clk);
        ack_i = 1'b0;
        check("mr_beat2_stb", stb_o, 1);
        check("mr_beat2_adr", adr_o, 26'h0000804);
        rst_i = 1'b1;
        #1;
        @(negedge clk); #1;
        check("mr_cyc", cyc_o, 0);
        check("mr_stb", stb_o, 0);
        check("mr_done", done_o, 0);
        check("mr_rdv", rdat_valid_o, 0);
        rst_i = 1'b0;
        n_dn = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (done_o || stb_o || rdat_valid_o) n_dn++;
        end
        check("mr_quiet_after", n_dn, 0);
        run_vec(vecs[5]);
        check("mr_new_status", r_status, 2'd0);
        check("mr_new_done", r_done, 1);
        check("mr_new_rdv", r_rdv, 2);

        // Back-to-back single reads with req_valid_i held high.
        acc0 = -1; acc1 = -1; d0 = -1; n_acc = 0; n_dn = 0; badr0 = '0; badr1 = '0;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_len_i = 3'd0; req_adr_i = 26'h0000400;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (n_acc == 1) req_adr_i = 26'h0000500;
            if (n_acc >= 2) req_valid_i = 1'b0;
            ack_i = stb_o; err_i = 1'b0; dat_i = 32'hC0DE0000 + 32'(c);
            if (stb_o && n_dn == 0) badr0 = adr_o;
            if (stb_o && n_dn == 1) badr1 = adr_o;
            #1;
            if (req_ready_o && req_valid_i) begin
                if (n_acc == 0) acc0 = c; else acc1 = c;
                n_acc++;
            end
            if (done_o) begin
                if (n_dn == 0) d0 = c;
                n_dn++;
            end
        end
        ack_i = 1'b0;
        check("b2b_accepts", n_acc, 2);
        check("b2b_dones", n_dn, 2);
        check("b2b_accept_after_done", acc1, d0 + 1);
        check("b2b_spacing", acc1 - acc0, 3);
        check("b2b_adr0", badr0, 26'h0000400);
        check("b2b_adr1", badr1, 26'h0000500);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Parametrised Wishbone B3 bus master that sits between the ARM-side memory request logic and the shared Wishbone interconnect. It accepts one command per transaction: read or write, start address, and beat count. It then runs the transaction as a single or incrementing-burst block cycle, moving data through per-beat read and write data handshakes. Each transaction ends with one completion status: OK, ERR or TIMEOUT.

## Interface
Parameters:
- AW, 26, address width
- DW, 32, data width; must be a multiple of 8
- MAXB, 8, maximum beats per command; power of 2, at least 2
- TMO, 255, cycles of stb without ack/err before abort; must be at least 1

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  command valid
- req_ready_o  out  1  command accepted when high with req_valid_i
- req_we_i  in  1  1 = write, 0 = read
- req_adr_i  in  AW  start byte address
- req_sel_i  in  DW/8  byte selects, applied to every beat
- req_len_i  in  clog2(MAXB)  beat count minus 1
- wdat_rd_o  out  1  combinational pop strobe; wdat_i is consumed in the same cycle (first-word-fall-through source)
- wdat_i  in  DW  write data
- rdat_valid_o  out  1  one-cycle strobe with rdat_o
- rdat_o  out  DW  read data
- done_o  out  1  one-cycle completion strobe
- status_o  out  2  0 OK, 1 ERR, 2 TIMEOUT; held until next done_o
- adr_o, dat_o, sel_o, we_o, stb_o, cyc_o  out  AW, DW, DW/8, 1, 1, 1  Wishbone master outputs, all registered
- cti_o  out  3  cycle type identifier
- dat_i, ack_i, err_i  in  DW, 1, 1  Wishbone slave responses

## Operation
- Reset values: cyc_o=stb_o=we_o=0, adr_o=dat_o=sel_o=0, cti_o=0, rdat_valid_o=done_o=0, status_o=0. req_ready_o is 0 during reset and 1 in the first IDLE cycle after reset.
- States are IDLE, BUS and DONE.
- IDLE:
  - req_ready_o=1.
  - On accept: latch we, sel and len; load adr_o=req_adr_i; set cyc_o=stb_o=1; go to BUS.
  - For writes, wdat_rd_o=1 in the accept cycle and dat_o is loaded from wdat_i.
- BUS, per beat:
  - On ack_i with err_i=0 and beats remaining:
    - adr_o increments by DW/8, wrapping modulo 2^AW.
    - stb_o stays high.
    - Writes assert wdat_rd_o in the same cycle and load the next dat_o.
    - The beat counter decrements and the timeout counter clears.
  - Reads: every ack_i drives rdat_valid_o=1 next cycle with rdat_o=the dat_i value sampled on that ack.
  - On ack_i of the last beat: drop cyc_o/stb_o at the next edge, status=OK, go to DONE.
- cti_o:
  - Single-beat command: 3'b000.
  - Burst command: 3'b010 on every beat except the last, 3'b111 on the last beat.
- err_i with stb_o high:
  - Abort: drop cyc_o/stb_o at the next edge, status=ERR, go to DONE.
  - Remaining write data is not popped.
  - err_i wins over a simultaneous ack_i; no rdat_valid_o for that beat.
- Timeout: a counter increments each BUS cycle without ack_i/err_i. When it reaches TMO, abort with status=TIMEOUT in the same way as err_i.
- DONE:
  - done_o=1 for one cycle and status_o updates.
  - req_ready_o=0; return to IDLE.
- ack_i/err_i are ignored outside BUS.
- Reset mid-transaction:
  - At the edge: cyc_o/stb_o=0, all counters clear, state=IDLE.
  - No done_o or rdat_valid_o is generated.

## Timing
- Accept edge to stb_o high: 1 cycle.
- Zero-wait slave (ack_i every stb cycle): N beats take N consecutive stb_o cycles with no idle gaps.
- Last ack edge: cyc_o falls; done_o is high in the following cycle.
- Command-to-command minimum spacing: N + 2 cycles. req_ready_o is next high in the cycle after done_o.
- rdat_valid_o lags its ack_i by exactly 1 cycle; the last rdat_valid_o coincides with done_o.
- Timeout: the abort edge is the TMO-th stalled cycle of a beat.

## Structure
- Shared package wb_pkg holds:
  - the state enum (IDLE/BUS/DONE);
  - status codes (WB_OK, WB_ERR, WB_TMO);
  - CTI constants (CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111).
- One sub-module, wb_tmo_cnt:
  - parametrised by TMO;
  - inputs: run, clear;
  - output: expired pulse.
- Beat counter and address incrementer stay inline.

## Test plan
- Single read, adr 0x0000100, len 0, ack after 2 wait cycles:
  - cti_o=000 throughout.
  - rdat_valid_o once with rdat_o=0xDEADBEEF.
  - done_o with status 0.
- 4-beat write burst, adr 0x3FFFFF8, zero-wait ack, wdat 0x11..0x44:
  - adr_o sequence 0x3FFFFF8, 0x3FFFFFC, 0x0000000, 0x0000004.
  - cti_o 010,010,010,111.
  - 4 wdat_rd_o pops.
- 8-beat read, err_i asserted together with ack_i on beat 3:
  - 2 rdat_valid_o strobes only.
  - status 1.
  - cyc_o low at the next edge.
- TMO=4, no ack:
  - stb_o high 4 cycles, then aborted.
  - status 2.
  - done_o once.
- Reset asserted mid-burst on beat 2:
  - cyc_o/stb_o 0 at the next edge.
  - No done_o.
  - A new command is accepted and completes OK.
- Back-to-back commands with req_valid_i held high:
  - Second accept occurs in the cycle after done_o.
  - No command is lost.
